reg_bus_initiator: RTL and testbench

REG_BUS_INITIATOR -- requirements
Module: reg_bus_initiator

---
 rtl/reg_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_reg_bus_initiator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: takes one read or write command at a time from the
// command port and drives the WRITE/READ strobes for that command. A read waits
// RD_LAT cycles before it samples READ_DATA. The result is then held on the
// response port until the consumer accepts it. The block also counts completed
// writes and reads, modulo 256.
//
// Handshake semantics (both ports): a transfer happens on the rising CLK edge
// where valid && ready are both 1. The producer holds valid and the payload
// steady until that edge. The response side keeps rsp_valid, rsp_rdata and
// rsp_addr constant until the edge where rsp_ready is sampled high.
module reg_bus_initiator #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              WRITE,
    output logic              READ,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA,
    output logic [7:0]        wr_count,
    output logic [7:0]        rd_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RSP_HOLD = 3'd4
    } state_t;

    // Read latency as a 3-bit load value for the wait counter.
    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [7:0]        wr_count_q, wr_count_d;
    logic [7:0]        rd_count_q, rd_count_d;

    logic accept;
    logic sample;

    // A command is taken only in IDLE. READ_DATA is sampled either at the end
    // of the issue cycle (zero latency) or on the last RD_WAIT cycle.
    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign sample = ((state_q == S_RD_ISSUE) && (LAT == 3'd0)) ||
                    ((state_q == S_RD_WAIT) && (lat_cnt_q == 3'd1));

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transaction in flight, with no overlap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = cmd_write ? S_WR_ISSUE : S_RD_ISSUE;
                end
            end
            S_WR_ISSUE: state_d = S_IDLE;
            S_RD_ISSUE: state_d = (LAT == 3'd0) ? S_RSP_HOLD : S_RD_WAIT;
            S_RD_WAIT: begin
                if (sample) begin
                    state_d = S_RSP_HOLD;
                end
            end
            S_RSP_HOLD: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state. The bus is driven to zero whenever no strobe
    // is active.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE) && !RST;
        WRITE      = (state_q == S_WR_ISSUE);
        READ       = (state_q == S_RD_ISSUE);
        ADDR       = (WRITE || READ) ? addr_q : '0;
        WRITE_DATA = WRITE ? wdata_q : '0;
        rsp_valid  = (state_q == S_RSP_HOLD);
        rsp_rdata  = rsp_rdata_q;
        rsp_addr   = rsp_addr_q;
        wr_count   = wr_count_q;
        rd_count   = rd_count_q;
        dbg_state  = state_q;
    end

    // Datapath next values: command latch, latency counter, response capture
    // and completion counters.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;

        if (accept) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end

        if (state_q == S_RD_ISSUE) begin
            lat_cnt_d = LAT;
        end else if ((state_q == S_RD_WAIT) && (lat_cnt_q != 3'd0)) begin
            lat_cnt_d = lat_cnt_q - 3'd1;
        end

        if (state_q == S_WR_ISSUE) begin
            wr_count_d = wr_count_q + 8'd1;
        end

        if (sample) begin
            rsp_rdata_d = READ_DATA;
            rsp_addr_d  = addr_q;
            rd_count_d  = rd_count_q + 8'd1;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator. Three instances with RD_LAT = 0, 1 and 7 share
// every input and run in lockstep. Each output is checked against values worked
// out from the command stream.
module tb_reg_bus_initiator;

    logic       CLK;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [1:0] cmd_wdata;
    logic       rsp_ready;
    logic [1:0] READ_DATA;

    logic       cmd_ready_a  [3];
    logic       rsp_valid_a  [3];
    logic [1:0] rsp_rdata_a  [3];
    logic [2:0] rsp_addr_a   [3];
    logic       write_a      [3];
    logic       read_a       [3];
    logic [2:0] addr_a       [3];
    logic [1:0] wdata_a      [3];
    logic [7:0] wr_count_a   [3];
    logic [7:0] rd_count_a   [3];
    logic [2:0] dbg_state_a  [3];

    int lat_of [3] = '{0, 1, 7};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
        reg_bus_initiator #(.ADDR_W(3), .DATA_W(2), .RD_LAT(LAT)) u_dut (
            .CLK        (CLK),
            .RST        (RST),
            .cmd_valid  (cmd_valid),
            .cmd_ready  (cmd_ready_a[g]),
            .cmd_write  (cmd_write),
            .cmd_addr   (cmd_addr),
            .cmd_wdata  (cmd_wdata),
            .rsp_valid  (rsp_valid_a[g]),
            .rsp_ready  (rsp_ready),
            .rsp_rdata  (rsp_rdata_a[g]),
            .rsp_addr   (rsp_addr_a[g]),
            .WRITE      (write_a[g]),
            .READ       (read_a[g]),
            .ADDR       (addr_a[g]),
            .WRITE_DATA (wdata_a[g]),
            .READ_DATA  (READ_DATA),
            .wr_count   (wr_count_a[g]),
            .rd_count   (rd_count_a[g]),
            .dbg_state  (dbg_state_a[g])
        );
    end

    // Clock and watchdog.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_wr   = 8'd0;
    logic [7:0] exp_rd   = 8'd0;
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All three instances are reset or idle: check the quiet-bus outputs.
    task automatic check_quiet(input string tag, input logic exp_ready);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.WRITE[%0d]", tag, i), write_a[i], 0);
            check($sformatf("%s.READ[%0d]", tag, i), read_a[i], 0);
            check($sformatf("%s.ADDR[%0d]", tag, i), addr_a[i], 0);
            check($sformatf("%s.WRITE_DATA[%0d]", tag, i), wdata_a[i], 0);
            check($sformatf("%s.rsp_valid[%0d]", tag, i), rsp_valid_a[i], 0);
            check($sformatf("%s.cmd_ready[%0d]", tag, i), cmd_ready_a[i], exp_ready);
            check($sformatf("%s.wr_count[%0d]", tag, i), wr_count_a[i], exp_wr);
            check($sformatf("%s.rd_count[%0d]", tag, i), rd_count_a[i], exp_rd);
        end
    endtask

    // Wait at negedges until every instance is ready. Give up after a fixed budget.
    task automatic wait_all_idle();
        int n = 0;
        while (!(cmd_ready_a[0] && cmd_ready_a[1] && cmd_ready_a[2]) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!(cmd_ready_a[0] && cmd_ready_a[1] && cmd_ready_a[2])) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_wait: cmd_ready not seen within 50 cycles");
        end
    endtask

    // Driver: one write. Returns at the negedge of the cycle after the strobe.
    task automatic do_write(input logic [2:0] addr, input logic [1:0] data);
        wait_all_idle();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~data;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr.WRITE[%0d]", i), write_a[i], 1);
            check($sformatf("wr.READ[%0d]", i), read_a[i], 0);
            check($sformatf("wr.ADDR[%0d]", i), addr_a[i], addr);
            check($sformatf("wr.WRITE_DATA[%0d]", i), wdata_a[i], data);
            check($sformatf("wr.cmd_ready[%0d]", i), cmd_ready_a[i], 0);
        end
        exp_wr = exp_wr + 8'd1;
        @(negedge CLK);
        check_quiet("wr_done", 1'b1);
    endtask

    // Driver: one read. READ_DATA carries v0 in cycle T, v1 in T+1, v7 in
    // T+7 and 'other' in every other cycle, so each instance captures a distinct
    // value. A new write is requested the whole time the read is outstanding, and
    // the response is held for 7 + extra cycles before rsp_ready is raised.
    task automatic do_read(input logic [2:0] addr, input logic [1:0] v0, input logic [1:0] v1,
                           input logic [1:0] v7, input logic [1:0] other, input int extra);
        logic [1:0] exp_val [3];
        logic [4:0] exp_rsp;
        exp_val[0] = v0;
        exp_val[1] = v1;
        exp_val[2] = v7;
        exp_q.push_back({addr, v1});
        wait_all_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_wdata = 2'b11;
        @(negedge CLK);
        cmd_write = 1'b1;
        cmd_addr  = ~addr;
        for (int k = 0; k <= 8; k++) begin
            READ_DATA = (k == 0) ? v0 : (k == 1) ? v1 : (k == 7) ? v7 : other;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rd.READ[%0d]@T+%0d", i, k), read_a[i], (k == 0));
                check($sformatf("rd.WRITE[%0d]@T+%0d", i, k), write_a[i], 0);
                check($sformatf("rd.ADDR[%0d]@T+%0d", i, k), addr_a[i], (k == 0) ? addr : 3'd0);
                check($sformatf("rd.cmd_ready[%0d]@T+%0d", i, k), cmd_ready_a[i], 0);
                check($sformatf("rd.rsp_valid[%0d]@T+%0d", i, k), rsp_valid_a[i], (k > lat_of[i]));
                if (k > lat_of[i]) begin
                    check($sformatf("rd.rsp_rdata[%0d]@T+%0d", i, k), rsp_rdata_a[i], exp_val[i]);
                    check($sformatf("rd.rsp_addr[%0d]@T+%0d", i, k), rsp_addr_a[i], addr);
                end
            end
            if (k == 2) begin
                exp_rsp = exp_q.pop_front();
                check("rd.scoreboard", {rsp_addr_a[1], rsp_rdata_a[1]}, exp_rsp);
            end
            @(negedge CLK);
        end
        exp_rd = exp_rd + 8'd1;
        READ_DATA = other;
        for (int h = 0; h <= extra; h++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("hold.rsp_valid[%0d]", i), rsp_valid_a[i], 1);
                check($sformatf("hold.rsp_rdata[%0d]", i), rsp_rdata_a[i], exp_val[i]);
                check($sformatf("hold.cmd_ready[%0d]", i), cmd_ready_a[i], 0);
                check($sformatf("hold.rd_count[%0d]", i), rd_count_a[i], exp_rd);
            end
            if (h == extra) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
                cmd_write = 1'b0;
            end
            @(negedge CLK);
        end
        rsp_ready = 1'b0;
        check_quiet("rd_done", 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_done.rsp_rdata[%0d]", i), rsp_rdata_a[i], exp_val[i]);
            check($sformatf("rd_done.rsp_addr[%0d]", i), rsp_addr_a[i], addr);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [1:0] data;
        logic [7:0] exp_wr_cnt;
        logic [7:0] exp_rd_cnt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 3'd0, 2'd3, 8'd1, 8'd0};
        vecs[1] = '{1'b0, 3'd5, 2'd2, 8'd1, 8'd1};
        vecs[2] = '{1'b1, 3'd7, 2'd1, 8'd2, 8'd1};
        vecs[3] = '{1'b0, 3'd2, 2'd1, 8'd2, 8'd2};
        vecs[4] = '{1'b1, 3'd4, 2'd2, 8'd3, 8'd2};
        vecs[5] = '{1'b0, 3'd7, 2'd3, 8'd3, 8'd3};
        vecs[6] = '{1'b0, 3'd0, 2'd0, 8'd3, 8'd4};
        vecs[7] = '{1'b1, 3'd5, 2'd0, 8'd4, 8'd4};

        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 3'd0;
        cmd_wdata = 2'd0;
        rsp_ready = 1'b0;
        READ_DATA = 2'd0;

        // Reset state, observed while RST is still high.
        repeat (3) @(negedge CLK);
        check_quiet("reset", 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset.rsp_rdata[%0d]", i), rsp_rdata_a[i], 0);
            check($sformatf("reset.rsp_addr[%0d]", i), rsp_addr_a[i], 0);
            check($sformatf("reset.dbg_state[%0d]", i), dbg_state_a[i], 0);
        end
        RST = 1'b0;
        @(negedge CLK);
        check_quiet("post_reset", 1'b1);

        // Table-driven mixed traffic.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data);
            end else begin
                do_read(vecs[v].addr, vecs[v].data ^ 2'b01, vecs[v].data,
                        vecs[v].data ^ 2'b10, ~vecs[v].data, 0);
            end
            check($sformatf("vec%0d.wr_count", v), wr_count_a[1], vecs[v].exp_wr_cnt);
            check($sformatf("vec%0d.rd_count", v), rd_count_a[1], vecs[v].exp_rd_cnt);
        end

        // Latency 0/1/7 sample points, with a longer stall on rsp_ready.
        do_read(3'd3, 2'b01, 2'b10, 2'b11, 2'b00, 3);

        // Reset while a read waits: instance 1 and instance 7 are in RD_WAIT.
        wait_all_idle();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd6;
        @(negedge CLK);
        cmd_valid = 1'b0;
        READ_DATA = 2'b11;
        @(negedge CLK);
        check("rst_mid.in_rd_wait", dbg_state_a[1], 3);
        RST = 1'b1;
        @(negedge CLK);
        exp_wr = 8'd0;
        exp_rd = 8'd0;
        check_quiet("rst_mid", 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_mid.rsp_rdata[%0d]", i), rsp_rdata_a[i], 0);
        end
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check_quiet($sformatf("rst_quiet%0d", c), 1'b1);
        end

        // A fresh command is accepted after reset.
        do_read(3'd6, 2'b10, 2'b01, 2'b00, 2'b11, 0);

        // 256 back-to-back writes: wr_count wraps back to 0 with no READ.
        for (int n = 0; n < 256; n++) begin
            do_write(3'(n), 2'(n >> 3));
        end
        check("wrap.wr_count", wr_count_a[1], 0);
        check("wrap.rd_count", rd_count_a[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
